// File: rtl/seq_pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_gen_pkg
//   Shared constants for the serial pattern generator and the sequence
//   detector benches that it drives.
//
//   Contents:
//     PW_DEF / RW_DEF / GW_DEF : default pattern, repetition and gap widths
//     IDLE / SEND / GAP        : FSM state encodings
//     DEF_PATTERN              : reset value of the generator's pattern register
//     cnt_w()                  : width of a counter that must hold 0..n
// -----------------------------------------------------------------------------
package seq_gen_pkg;

    localparam int PW_DEF = 4;
    localparam int RW_DEF = 4;
    localparam int GW_DEF = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [PW_DEF-1:0] DEF_PATTERN = 4'b1011;

    // Bits needed to represent every value from 0 up to and including n.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
//   Serial pattern transmitter. Sends a PW-bit pattern MSB first, one bit per
//   clock, repeated rep_cnt times with gap_len idle cycles between repetitions.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous, active-high reset
//     start      in   transfer request, sampled only while idle
//     pattern    in   [PW] bits to send, MSB first (latched on start)
//     rep_cnt    in   [RW] number of repetitions (latched on start)
//     gap_len    in   [GW] idle cycles between repetitions (latched on start)
//     hold       in   stall; freezes transmission while high
//     out        out  serial data
//     out_valid  out  out carries a pattern bit this cycle
//     busy       out  transfer in progress
//     done       out  one-cycle pulse at the end of a transfer
// -----------------------------------------------------------------------------
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int              PW          = PW_DEF,
    parameter int              RW          = RW_DEF,
    parameter int              GW          = GW_DEF,
    parameter logic [PW-1:0]   DEF_PATTERN = seq_gen_pkg::DEF_PATTERN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] pattern,
    input  logic [RW-1:0] rep_cnt,
    input  logic [GW-1:0] gap_len,
    input  logic          hold,
    output logic          out,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);

    localparam int BW = cnt_w(PW);

    logic [1:0]    state;
    logic [PW-1:0] pat_q;     // latched pattern, reloaded at each repetition
    logic [PW-1:0] sh_q;      // remaining bits of the current repetition
    logic [BW-1:0] bit_q;     // bits already emitted in this repetition
    logic [RW-1:0] rep_q;     // repetitions still to finish, current included
    logic [GW-1:0] gap_q;     // latched gap length
    logic [GW-1:0] gap_cnt;   // gap cycles still to spend

    // NOTE: every register, including the pattern and counters, gets a reset
    // value so a mid-transfer reset leaves no stale repetition behind.
    // NOTE: state updates use non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= DEF_PATTERN;
            sh_q      <= '0;
            bit_q     <= '0;
            rep_q     <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // hold has no effect here; the first bit leaves on the
                    // accepting edge.
                    if (start) begin
                        if (rep_cnt != '0) begin
                            pat_q     <= pattern;
                            sh_q      <= pattern << 1;
                            bit_q     <= BW'(1);
                            rep_q     <= rep_cnt;
                            gap_q     <= gap_len;
                            gap_cnt   <= '0;
                            out       <= pattern[PW-1];
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                            state     <= SEND;
                        end else begin
                            // Empty transfer: just acknowledge it.
                            done <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (hold) begin
                        out_valid <= 1'b0;
                    end else if (bit_q < BW'(PW)) begin
                        out       <= sh_q[PW-1];
                        sh_q      <= sh_q << 1;
                        bit_q     <= bit_q + BW'(1);
                        out_valid <= 1'b1;
                    end else if (rep_q > RW'(1)) begin
                        rep_q <= rep_q - RW'(1);
                        if (gap_q == '0) begin
                            // Back-to-back repetition: MSB follows LSB with
                            // no bubble.
                            out       <= pat_q[PW-1];
                            sh_q      <= pat_q << 1;
                            bit_q     <= BW'(1);
                            out_valid <= 1'b1;
                        end else begin
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            gap_cnt   <= gap_q;
                            state     <= GAP;
                        end
                    end else begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        bit_q     <= '0;
                        rep_q     <= '0;
                        state     <= IDLE;
                    end
                end

                GAP: begin
                    if (hold) begin
                        out_valid <= 1'b0;
                    end else if (gap_cnt > GW'(1)) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else begin
                        // This edge closes the final gap cycle, so the next
                        // repetition's MSB leaves now.
                        gap_cnt   <= '0;
                        out       <= pat_q[PW-1];
                        sh_q      <= pat_q << 1;
                        bit_q     <= BW'(1);
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_gen
//   Directed bench for seq_pattern_gen. A slot-list model (each transfer is a
//   flat list of bit / gap slots consumed one per un-held edge) is checked
//   against the DUT every cycle; each directed transfer also pins latency,
//   bit count, bit string and 1011-detector hits to hand-computed values.
// -----------------------------------------------------------------------------
module tb_seq_pattern_gen;
    import seq_gen_pkg::*;

    localparam int PW = 4;
    localparam int RW = 4;
    localparam int GW = 4;
    localparam int GAP_SLOT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [RW-1:0] rep_cnt = '0;
    logic [GW-1:0] gap_len = '0;
    logic          out;
    logic          out_valid;
    logic          busy;
    logic          done;

    seq_pattern_gen #(
        .PW         (PW),
        .RW         (RW),
        .GW         (GW),
        .DEF_PATTERN(DEF_PATTERN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .rep_cnt  (rep_cnt),
        .gap_len  (gap_len),
        .hold     (hold),
        .out      (out),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int   slots[$];
    bit   m_act = 1'b0;
    logic m_out = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;

    // observation of the DUT stream for the directed checks
    bit   cap[$];
    int   edge_n = 0;
    int   done_edge = -1;

    task automatic model_step();
        int s;
        m_done = 1'b0;
        if (!m_act) begin
            if (start) begin
                if (rep_cnt != '0) begin
                    slots.delete();
                    for (int r = 0; r < int'(rep_cnt); r++) begin
                        if (r > 0)
                            for (int g = 0; g < int'(gap_len); g++) slots.push_back(GAP_SLOT);
                        for (int b = PW - 1; b >= 0; b--) slots.push_back(int'(pattern[b]));
                    end
                    s       = slots.pop_front();
                    m_out   = s[0];
                    m_valid = 1'b1;
                    m_busy  = 1'b1;
                    m_act   = 1'b1;
                end else begin
                    m_done = 1'b1;
                end
            end
        end else if (hold) begin
            m_valid = 1'b0;
        end else if (slots.size() == 0) begin
            m_act   = 1'b0;
            m_busy  = 1'b0;
            m_done  = 1'b1;
            m_out   = 1'b0;
            m_valid = 1'b0;
        end else begin
            s = slots.pop_front();
            if (s == GAP_SLOT) begin
                m_out   = 1'b0;
                m_valid = 1'b0;
            end else begin
                m_out   = s[0];
                m_valid = 1'b1;
            end
        end
    endtask

    // single compare process: model advance on each edge, compare 1 ns later
    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            slots.delete();
            m_act = 1'b0; m_out = 1'b0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            model_step();
        end
        #1;
        check("cycle {out,valid,busy,done}", {60'd0, out, out_valid, busy, done},
              {60'd0, m_out, m_valid, m_busy, m_done});
        if (!rst) begin
            edge_n++;
            if (out_valid) cap.push_back(out);
            if (done && done_edge < 0) done_edge = edge_n;
        end
    end

    function automatic int count_1011();
        int n = 0;
        for (int i = 3; i < cap.size(); i++)
            if (cap[i-3] && !cap[i-2] && cap[i-1] && cap[i]) n++;
        return n;
    endfunction

    // Called at a negedge; returns at the negedge right after done is seen,
    // so the next call starts during the done cycle.
    task automatic run_xfer(input string name, input logic [PW-1:0] pat, input int rep,
                            input int gap, input int hold_at, input int hold_len,
                            input int mid_j, input logic [63:0] exp_bits,
                            input int exp_n, input int exp_done, input int exp_det);
        int t0;
        logic [63:0] v;
        pattern   = pat;
        rep_cnt   = RW'(rep);
        gap_len   = GW'(gap);
        start     = 1'b1;
        hold      = (hold_at == 0 && hold_len > 0);
        cap.delete();
        done_edge = -1;
        t0        = edge_n + 1;
        for (int j = 1; j <= 200 && done_edge < 0; j++) begin
            @(negedge clk);
            start = (j == mid_j);
            if (j == mid_j) begin
                pattern = '0;
                rep_cnt = '1;
                gap_len = '1;
            end
            hold = (j >= hold_at && j < hold_at + hold_len);
        end
        start = 1'b0;
        hold  = 1'b0;
        check({name, " done latency"}, done_edge - t0, exp_done);
        check({name, " valid bits"}, cap.size(), exp_n);
        v = '0;
        foreach (cap[i]) v = {v[62:0], cap[i]};
        if (exp_n <= 64) check({name, " bit string"}, v, exp_bits);
        if (exp_det >= 0) check({name, " 1011 hits"}, count_1011(), exp_det);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset outputs", {60'd0, out, out_valid, busy, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        //        name          pat      rep gap hat hlen mid bits                         n   done det
        run_xfer("single",     4'b1011,  1, 0,  0,  0,  0, 64'b1011,                     4,  4, 1);
        run_xfer("b2b x3",     4'b1011,  3, 0,  0,  0,  0, 64'b101110111011,            12, 12, 3);
        run_xfer("gap2",       4'b1011,  2, 2,  0,  0,  0, 64'b10111011,                 8, 10, 2);
        run_xfer("hold3",      4'b1011,  1, 0,  2,  3,  0, 64'b1011,                     4,  7, 1);
        run_xfer("mid start",  4'b1011,  1, 0,  0,  0,  2, 64'b1011,                     4,  4, 1);
        run_xfer("rep0",       4'b1011,  0, 0,  0,  0,  0, 64'd0,                        0,  0, 0);
        run_xfer("hold@start", 4'b1011,  1, 0,  0,  2,  0, 64'b1011,                     4,  5, 1);
        run_xfer("gap hold",   4'b1011,  2, 3,  5,  2,  0, 64'b10111011,                 8, 13, 2);
        run_xfer("0110 gap1",  4'b0110,  2, 1,  0,  0,  0, 64'b01100110,                 8,  9, 0);
        run_xfer("max rep",    4'b1100, 15, 0,  0,  0,  0, {4'd0, {15{4'b1100}}},       60, 60, 0);

        // reset in the middle of a transfer
        pattern   = 4'b1011;
        rep_cnt   = RW'(1);
        gap_len   = '0;
        start     = 1'b1;
        done_edge = -1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("reset immediate", {60'd0, out, out_valid, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no done after abort", done_edge, -1);
        run_xfer("after reset", 4'b1011, 1, 0, 0, 0, 0, 64'b1011, 4, 4, 1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
